// File: rtl/bfedp_pkg.sv
// Shared constants and state type for the bit-sparse dot-product front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bfedp_pkg;

  localparam int NUM_W      = 8;  // weights per group, one per bFEDP activation lane
  localparam int NUM_COLS   = 4;  // bit-plane slots per output beat
  localparam int OFF_W      = 3;  // bits per shift offset
  localparam int MAG_W      = 7;  // sign-magnitude magnitude width
  localparam int NUM_PLANES = 7;  // magnitude bit-planes per weight

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P0    = 2'd1,
    P1    = 2'd2
  } enc_state_e;

endpackage

// File: rtl/bw_plane_pick4.sv
// Picks the four lowest set bit-plane indices of a 7-bit mask, ascending.
// Latency: combinational.
// Backpressure: none; pure function of the mask.
module bw_plane_pick4
  import bfedp_pkg::*;
(
  input  logic [NUM_PLANES-1:0]     mask,
  output logic [NUM_COLS*OFF_W-1:0] idx,      // slot s index at [3s+2:3s], 0 when slot unused
  output logic [NUM_COLS-1:0]       idx_vld,  // slot s holds a real plane
  output logic [NUM_PLANES-1:0]     resid     // set planes not picked into any slot
);

  // Walk planes from LSB up, filling slots in order until four are taken.
  always_comb begin
    int cnt;
    idx     = '0;
    idx_vld = '0;
    resid   = mask;
    cnt     = 0;
    for (int b = 0; b < NUM_PLANES; b++) begin
      if (mask[b] && (cnt < NUM_COLS)) begin
        idx[cnt*OFF_W +: OFF_W] = OFF_W'(b);
        idx_vld[cnt]            = 1'b1;
        resid[b]                = 1'b0;
        cnt                     = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/bw_col_encoder.sv
// Int8 weight group -> sign-magnitude bit-plane columns, 1 or 2 beats per group.
// Latency: 1 cycle from input accept to beat 0; beat 1 (if any) follows directly.
// Backpressure: outputs hold while out_valid & !out_ready; in_ready only when empty or last beat leaves.
// Optional BWENC_STATS_EN adds stat_groups / stat_passes counters.
module bw_col_encoder
  import bfedp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_weights,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  weight_column0,
  output logic [7:0]  weight_column1,
  output logic [7:0]  weight_column2,
  output logic [7:0]  weight_column3,
  output logic [7:0]  weight_sign,
  output logic [11:0] shift_offset,
  output logic        out_first,
  output logic        out_last
`ifdef BWENC_STATS_EN
  ,
  output logic [31:0] stat_groups,
  output logic [31:0] stat_passes
`endif
);

  // ---------------- input conversion ----------------
  logic [NUM_W-1:0]                 sign_c;
  logic [NUM_W-1:0][MAG_W-1:0]      mag_c;
  logic [NUM_PLANES-1:0]            mask_c;
  logic [NUM_PLANES-1:0][NUM_W-1:0] plane_c;

  // Sign-magnitude conversion, plane mask and bit-plane transpose of the incoming group.
  always_comb begin
    logic [7:0] w;
    sign_c  = '0;
    mag_c   = '0;
    mask_c  = '0;
    plane_c = '0;
    w       = '0;
    for (int k = 0; k < NUM_W; k++) begin
      w         = in_weights[8*k +: 8];
      sign_c[k] = w[7];
      if (w == 8'h80)
        mag_c[k] = 7'h7F;            // -128 has no 7-bit magnitude; saturate
      else if (w[7])
        mag_c[k] = 7'(8'd0 - w);
      else
        mag_c[k] = w[6:0];
      mask_c = mask_c | mag_c[k];
    end
    for (int b = 0; b < NUM_PLANES; b++)
      for (int k = 0; k < NUM_W; k++)
        plane_c[b][k] = mag_c[k][b];
  end

  // ---------------- plane selection ----------------
  logic [NUM_COLS*OFF_W-1:0] idx0, idx1;
  logic [NUM_COLS-1:0]       vld0, vld1;
  logic [NUM_PLANES-1:0]     resid0;
  logic [NUM_PLANES-1:0]     resid1_unused;  // at most 7 planes, so always empty

  bw_plane_pick4 u_pick0 (
    .mask    (mask_c),
    .idx     (idx0),
    .idx_vld (vld0),
    .resid   (resid0)
  );

  bw_plane_pick4 u_pick1 (
    .mask    (resid0),
    .idx     (idx1),
    .idx_vld (vld1),
    .resid   (resid1_unused)
  );

  logic [NUM_COLS-1:0][NUM_W-1:0] b0_col_c, b1_col_c;
  logic                           two_beat_c;

  // Fill each beat's slots with the selected planes; unused slots stay zero.
  // The picker already drives 0 for unused offsets, so idx feeds shift_offset directly.
  always_comb begin
    b0_col_c = '0;
    b1_col_c = '0;
    for (int s = 0; s < NUM_COLS; s++) begin
      if (vld0[s]) b0_col_c[s] = plane_c[idx0[s*OFF_W +: OFF_W]];
      if (vld1[s]) b1_col_c[s] = plane_c[idx1[s*OFF_W +: OFF_W]];
    end
    two_beat_c = |resid0;
  end

  // ---------------- FSM, hold and output registers ----------------
  enc_state_e                     state_q, state_d;
  logic [NUM_COLS-1:0][NUM_W-1:0] col_q, col_d;
  logic [NUM_COLS*OFF_W-1:0]      off_q, off_d;
  logic [NUM_W-1:0]               sign_q, sign_d;
  logic                           first_q, first_d;
  logic                           last_q, last_d;
  logic [NUM_COLS-1:0][NUM_W-1:0] hcol_q, hcol_d;   // pass-1 columns waiting behind beat 0
  logic [NUM_COLS*OFF_W-1:0]      hoff_q, hoff_d;

  logic out_hs, accept;

  assign out_valid = (state_q != EMPTY);
  assign out_hs    = out_valid & out_ready;
  assign in_ready  = (state_q == EMPTY) | (out_hs & last_q);
  assign accept    = in_valid & in_ready;

  // Next state and next beat: a new group loads beat 0 and parks pass 1 in the hold regs.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    off_d   = off_q;
    sign_d  = sign_q;
    first_d = first_q;
    last_d  = last_q;
    hcol_d  = hcol_q;
    hoff_d  = hoff_q;
    if (accept) begin
      state_d = P0;
      col_d   = b0_col_c;
      off_d   = idx0;
      sign_d  = sign_c;
      first_d = 1'b1;
      last_d  = ~two_beat_c;
      hcol_d  = b1_col_c;
      hoff_d  = idx1;
    end else if (out_hs) begin
      if (!last_q) begin
        state_d = P1;
        col_d   = hcol_q;
        off_d   = hoff_q;
        first_d = 1'b0;
        last_d  = 1'b1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State and datapath registers; reset discards any group in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      col_q   <= '0;
      off_q   <= '0;
      sign_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      hcol_q  <= '0;
      hoff_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      off_q   <= off_d;
      sign_q  <= sign_d;
      first_q <= first_d;
      last_q  <= last_d;
      hcol_q  <= hcol_d;
      hoff_q  <= hoff_d;
    end
  end

  assign weight_column0 = col_q[0];
  assign weight_column1 = col_q[1];
  assign weight_column2 = col_q[2];
  assign weight_column3 = col_q[3];
  assign weight_sign    = sign_q;
  assign shift_offset   = off_q;
  assign out_first      = first_q;
  assign out_last       = last_q;

`ifdef BWENC_STATS_EN
  logic [31:0] stat_groups_q, stat_groups_d;
  logic [31:0] stat_passes_q, stat_passes_d;

  // Free-running, wrapping counts of accepted groups and emitted beats.
  always_comb begin
    stat_groups_d = stat_groups_q + {31'd0, accept};
    stat_passes_d = stat_passes_q + {31'd0, out_hs};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_groups_q <= '0;
      stat_passes_q <= '0;
    end else begin
      stat_groups_q <= stat_groups_d;
      stat_passes_q <= stat_passes_d;
    end
  end

  assign stat_groups = stat_groups_q;
  assign stat_passes = stat_passes_q;
`endif

endmodule

// File: tb/tb_bw_col_encoder.sv
// Self-checking bench for bw_col_encoder: directed cases plus random traffic vs a plane-list model.
// Latency: n/a (testbench).
// Backpressure: random out_ready stalls in the random phase.
module tb_bw_col_encoder;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_weights;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  weight_column0, weight_column1, weight_column2, weight_column3;
  logic [7:0]  weight_sign;
  logic [11:0] shift_offset;
  logic        out_first, out_last;
`ifdef BWENC_STATS_EN
  logic [31:0] stat_groups, stat_passes;
`endif

  int errors = 0;
  int checks = 0;

  // {col0,col1,col2,col3,sign,offset,first,last}
  logic [53:0] obs_vec;
  assign obs_vec = {weight_column0, weight_column1, weight_column2, weight_column3,
                    weight_sign, shift_offset, out_first, out_last};

  logic [53:0] exp_q[$];

  bw_col_encoder dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_weights     (in_weights),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .weight_column0 (weight_column0),
    .weight_column1 (weight_column1),
    .weight_column2 (weight_column2),
    .weight_column3 (weight_column3),
    .weight_sign    (weight_sign),
    .shift_offset   (shift_offset),
    .out_first      (out_first),
    .out_last       (out_last)
`ifdef BWENC_STATS_EN
    ,
    .stat_groups    (stat_groups),
    .stat_passes    (stat_passes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list the non-zero magnitude planes, then deal them four per beat.
  function automatic void model_push(input logic [63:0] w);
    int          mag[8];
    logic [7:0]  sg;
    int          planes[$];
    int          nb;
    int          v;
    logic [7:0]  cols[4];
    logic [11:0] off;
    for (int k = 0; k < 8; k++) begin
      v     = int'($signed(w[8*k +: 8]));
      sg[k] = (v < 0);
      if (v < 0) v = -v;
      if (v > 127) v = 127;
      mag[k] = v;
    end
    for (int b = 0; b < 7; b++) begin
      bit any = 0;
      for (int k = 0; k < 8; k++) if (((mag[k] >> b) & 1) == 1) any = 1;
      if (any) planes.push_back(b);
    end
    nb = (planes.size() > 4) ? 2 : 1;
    for (int j = 0; j < nb; j++) begin
      off = 12'h000;
      for (int s = 0; s < 4; s++) begin
        int i = 4*j + s;
        cols[s] = 8'h00;
        if (i < planes.size()) begin
          for (int k = 0; k < 8; k++) cols[s][k] = ((mag[k] >> planes[i]) & 1) == 1;
          off = off | 12'(planes[i] << (3*s));
        end
      end
      exp_q.push_back({cols[0], cols[1], cols[2], cols[3], sg, off, (j == 0), (j == nb-1)});
    end
  endfunction

  function automatic logic [63:0] rand_group();
    logic [63:0] g;
    int mode;
    mode = int'($urandom_range(0, 3));
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       g[8*k +: 8] = 8'($urandom);
        1:       g[8*k +: 8] = 8'($urandom_range(0, 14)) - 8'd7;
        2:       g[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'h00;
        default: g[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F;
      endcase
    end
    return g;
  endfunction

  // Present a group and return at the negedge after it was accepted, outputs showing beat 0.
  task automatic put_group(input logic [63:0] w);
    int n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_weights = w;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL put_group_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_weights = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
    checks++;
    if (obs_vec !== 54'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", obs_vec);
    end
    rstn = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_vec !== 54'h0) begin
      errors++;
      $display("FAIL reset_release: out_valid=%0b in_ready=%0b vec=%h, required 0/1/0", out_valid, in_ready, obs_vec);
    end
`ifdef BWENC_STATS_EN
    checks++;
    if (stat_groups !== 32'd0 || stat_passes !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: groups=%0d passes=%0d, required 0/0", stat_groups, stat_passes);
    end
`endif
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    put_group(64'h0);
    checks++;
    if (out_valid !== 1'b1 || obs_vec !== {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_group: valid=%0b vec=%h, required 1/%h", out_valid, obs_vec,
               {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 1'b1, 1'b1});
    end
    put_group({8{8'h05}});
    checks++;
    if (out_valid !== 1'b1 || obs_vec !== {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL fives_group: valid=%0b vec=%h, required 1/%h", out_valid, obs_vec,
               {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h010, 1'b1, 1'b1});
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_two_beat();
    logic [7:0] w0[2];
    logic [7:0] sg[2];
    w0[0] = 8'h7F; w0[1] = 8'h80;
    sg[0] = 8'h00; sg[1] = 8'h01;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      put_group({56'h0, w0[t]});
      checks++;
      if (out_valid !== 1'b1 || obs_vec !== {8'h01, 8'h01, 8'h01, 8'h01, sg[t], 12'h688, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL two_beat_b0[%0d]: valid=%0b vec=%h, required 1/%h", t, out_valid, obs_vec,
                 {8'h01, 8'h01, 8'h01, 8'h01, sg[t], 12'h688, 1'b1, 1'b0});
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || obs_vec !== {8'h01, 8'h01, 8'h01, 8'h00, sg[t], 12'h1AC, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL two_beat_b1[%0d]: valid=%0b vec=%h, required 1/%h", t, out_valid, obs_vec,
                 {8'h01, 8'h01, 8'h01, 8'h00, sg[t], 12'h1AC, 1'b0, 1'b1});
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL two_beat_drain[%0d]: out_valid=%0b, required 0", t, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] g[4];
    logic [53:0] e[4];
    g[0] = {8{8'h05}}; e[0] = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h010, 1'b1, 1'b1};
    g[1] = {8{8'h01}}; e[1] = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 1'b1, 1'b1};
    g[2] = {8{8'h40}}; e[2] = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 12'h006, 1'b1, 1'b1};
    g[3] = {8{8'h0C}}; e[3] = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h01A, 1'b1, 1'b1};
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_weights = {56'h0, 8'h7F};
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_weights = g[0];
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          obs_vec !== {8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 12'h688, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b in_ready=%0b vec=%h, required 1/0/%h", i, out_valid,
                 in_ready, obs_vec, {8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 12'h688, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL p0_not_last_ready: in_ready=%0b, required 0", in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || obs_vec !== {8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 12'h1AC, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL release_b1: in_ready=%0b vec=%h, required 1/%h", in_ready, obs_vec,
               {8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 12'h1AC, 1'b0, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) in_weights = g[i+1];
      else       in_valid   = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || obs_vec !== e[i]) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: valid=%0b vec=%h, required 1/%h", i, out_valid, obs_vec, e[i]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b1;
    put_group({56'h0, 8'h7F});
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_in_p1: valid=%0b first=%0b, required 1/0", out_valid, out_first);
    end
    rstn = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_vec !== 54'h0) begin
      errors++;
      $display("FAIL mid_reset_release: valid=%0b in_ready=%0b vec=%h, required 0/1/0", out_valid, in_ready, obs_vec);
    end
    put_group({8{8'h05}});
    checks++;
    if (out_valid !== 1'b1 || obs_vec !== {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_next: valid=%0b vec=%h, required 1/%h", out_valid, obs_vec,
               {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 12'h010, 1'b1, 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] cur;
    bit          hold = 0;
    int          n;
    exp_q.delete();
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!hold) begin
        cur        = rand_group();
        in_valid   = ($urandom_range(0, 3) != 0);
        in_weights = cur;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious[%0d]: vec=%h, required no beat", c, obs_vec);
        end else begin
          if (obs_vec !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_beat[%0d]: vec=%h, required %h", c, obs_vec, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) model_push(cur);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    #1;
    while (out_valid && n < 20) begin
      checks++;
      if (exp_q.size() == 0 || obs_vec !== exp_q[0]) begin
        errors++;
        $display("FAIL rand_drain[%0d]: vec=%h, queued=%0d", n, obs_vec, exp_q.size());
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_leftover: queued=%0d out_valid=%0b, required 0/0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_back_to_back();
    test_reset_mid_group();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
